barrido_display: RTL and testbench



---
 rtl/barrido_display.sv | 132 +++++++++++++
 tb/tb_barrido_display.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrido_display.sv
// barrido_display: multiplexed scan for a 4-digit common-anode display.
// Double-buffered value, dead time between digits, frame-aligned commit.
module barrido_display #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int DEAD  = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] Dato,
  input  logic               Cargar,
  input  logic [N_DIG-1:0]   Apagar,
  input  logic               SupCeros,
  output logic [3:0]         Ver,
  output logic [N_DIG-1:0]   Anodo,
  output logic               Ocupado,
  output logic               Listo
);

  localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [0:0] S_DEAD = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  typedef logic [N_DIG-1:0][3:0] nib_t;

  logic [0:0]       st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  nib_t             mos_q, mos_d;
  nib_t             buf_q, buf_d;
  logic             ocu_q, ocu_d;
  logic             lis_q, lis_d;
  logic [3:0]       ver_q, ver_d;
  logic [N_DIG-1:0] an_q, an_d;

  // A digit is dark if masked, or if it and every higher digit is zero.
  function automatic logic blank(
    input logic [IW-1:0]    i,
    input nib_t             m,
    input logic [N_DIG-1:0] ap,
    input logic             sc
  );
    logic z;
    z = 1'b1;
    for (int k = 0; k < N_DIG; k++) begin
      if (k >= int'(i) && m[k] != 4'h0) z = 1'b0;
    end
    return ap[i] | (sc & (i != '0) & z);
  endfunction

  // Next-state: phase timing, digit advance, frame commit, load.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    mos_d = mos_q;
    buf_d = buf_q;
    ocu_d = ocu_q;
    lis_d = 1'b0;
    unique case (st_q)
      S_DEAD: begin
        if (cnt_q == CW'(DEAD - 1)) begin
          st_d  = S_SHOW;
          cnt_d = '0;
        end
      end
      default: begin
        if (cnt_q == CW'(DIV - 1)) begin
          st_d  = S_DEAD;
          cnt_d = '0;
          if (idx_q == IW'(N_DIG - 1)) begin
            idx_d = '0;
            if (ocu_q) begin
              mos_d = buf_q;
              ocu_d = 1'b0;
              lis_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase
    if (Cargar) begin
      buf_d = Dato;
      ocu_d = 1'b1;
    end
    ver_d = ver_q;
    if (st_q == S_SHOW && st_d == S_DEAD) begin
      ver_d = mos_d[idx_d];
    end
    an_d = '1;
    if (st_d == S_SHOW &&
        !blank(idx_d, mos_d, Apagar, SupCeros)) begin
      an_d[idx_d] = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_DEAD;
      cnt_q <= '0;
      idx_q <= '0;
      mos_q <= '0;
      buf_q <= '0;
      ocu_q <= 1'b0;
      lis_q <= 1'b0;
      ver_q <= 4'h0;
      an_q  <= '1;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mos_q <= mos_d;
      buf_q <= buf_d;
      ocu_q <= ocu_d;
      lis_q <= lis_d;
      ver_q <= ver_d;
      an_q  <= an_d;
    end
  end

  assign Ver     = ver_q;
  assign Anodo   = an_q;
  assign Ocupado = ocu_q;
  assign Listo   = lis_q;

endmodule

// File: tb/tb_barrido_display.sv
// tb_barrido_display: directed + random scan checks
// against a frame-position reference model.
module tb_barrido_display;

  localparam int ND = 4;
  localparam int DV = 8;
  localparam int DT = 2;
  localparam int SL = DV + DT;
  localparam int FR = ND * SL;

  logic        clk;
  logic        rst_n;
  logic [15:0] Dato;
  logic        Cargar;
  logic [3:0]  Apagar;
  logic        SupCeros;
  logic [3:0]  Ver;
  logic [3:0]  Anodo;
  logic        Ocupado;
  logic        Listo;

  int total  = 0;
  int passed = 0;

  int          t;
  logic [15:0] mos;
  logic [15:0] bfm;
  bit          pend;
  bit          lis;
  logic [3:0]  ap_s;
  bit          sc_s;

  barrido_display #(
    .N_DIG(ND), .DIV(DV), .DEAD(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Dato(Dato),
    .Cargar(Cargar),
    .Apagar(Apagar),
    .SupCeros(SupCeros),
    .Ver(Ver),
    .Anodo(Anodo),
    .Ocupado(Ocupado),
    .Listo(Listo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0d observed=%h expected=%h",
                tag, t, obs, exp);
  endtask

  function automatic int cur_dig();
    return (t % FR) / SL;
  endfunction

  function automatic logic [3:0] e_ver();
    logic [15:0] s;
    s = mos >> (4 * cur_dig());
    return s[3:0];
  endfunction

  function automatic logic [3:0] e_an();
    int d;
    bit show;
    bit bl;
    logic [15:0] hi;
    logic [3:0] one;
    d = cur_dig();
    show = ((t % FR) % SL) >= DT;
    hi = mos >> (4 * d);
    bl = ap_s[d] || (sc_s && d > 0 && hi == 16'h0);
    one = 4'b0001;
    if (show && !bl) return ~(one << d);
    return 4'hF;
  endfunction

  task automatic check_all();
    chk("anodo", 16'(Anodo), 16'(e_an()));
    chk("ver", 16'(Ver), 16'(e_ver()));
    chk("ocupado", 16'(Ocupado), 16'(pend));
    chk("listo", 16'(Listo), 16'(lis));
  endtask

  task automatic model_reset();
    t = 0;
    mos = '0;
    bfm = '0;
    pend = 0;
    lis = 0;
    ap_s = '0;
    sc_s = 0;
  endtask

  task automatic cyc(input logic c,
                     input logic [15:0] d,
                     input logic [3:0] a,
                     input logic s);
    Cargar = c;
    Dato = d;
    Apagar = a;
    SupCeros = s;
    @(posedge clk);
    t++;
    lis = 0;
    if (t % FR == 0 && pend) begin
      mos = bfm;
      pend = 0;
      lis = 1;
    end
    if (c) begin
      bfm = d;
      pend = 1;
    end
    ap_s = a;
    sc_s = s;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n,
                      input logic [3:0] a,
                      input logic s);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), a, s);
  endtask

  task automatic to_pos(input int p,
                        input logic [3:0] a,
                        input logic s);
    for (int i = 0; i < FR && (t % FR) != p; i++)
      cyc(1'b0, 16'($urandom), a, s);
  endtask

  initial begin
    rst_n = 1'b0;
    Cargar = 1'b0;
    Dato = '0;
    Apagar = '0;
    SupCeros = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();

    // free-running scan, nothing loaded
    idle(2 * FR, 4'h0, 1'b0);

    // load mid-frame, commit at frame end
    to_pos(15, 4'h0, 1'b0);
    cyc(1'b1, 16'h12AF, 4'h0, 1'b0);
    to_pos(0, 4'h0, 1'b0);
    idle(FR, 4'h0, 1'b0);

    // overwrite, then load in the commit cycle
    to_pos(5, 4'h0, 1'b0);
    cyc(1'b1, 16'h1111, 4'h0, 1'b0);
    idle(3, 4'h0, 1'b0);
    cyc(1'b1, 16'h2222, 4'h0, 1'b0);
    to_pos(FR - 1, 4'h0, 1'b0);
    cyc(1'b1, 16'h3333, 4'h0, 1'b0);
    idle(2 * FR, 4'h0, 1'b0);

    // leading-zero suppression
    cyc(1'b1, 16'h0050, 4'h0, 1'b1);
    to_pos(0, 4'h0, 1'b1);
    idle(FR, 4'h0, 1'b1);
    cyc(1'b1, 16'h0000, 4'h0, 1'b1);
    to_pos(0, 4'h0, 1'b1);
    idle(FR, 4'h0, 1'b1);

    // blank mask
    cyc(1'b1, 16'h9876, 4'b0101, 1'b0);
    to_pos(0, 4'b0101, 1'b0);
    idle(FR, 4'b0101, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic c;
      logic [15:0] d;
      logic [3:0] a;
      logic s;
      c = ($urandom % 12) == 0;
      d = 16'($urandom);
      if ($urandom % 2 == 0) d[15:8] = 8'h0;
      if ($urandom % 3 == 0) d[7:4] = 4'h0;
      a = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      s = 1'($urandom);
      cyc(c, d, a, s);
    end

    // asynchronous reset during digit 2 with a pending load
    cyc(1'b1, 16'hBEEF, 4'h0, 1'b0);
    to_pos(25, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_anodo", 16'(Anodo), 16'h000F);
    chk("rst_ocupado", 16'(Ocupado), 16'h0);
    chk("rst_ver", 16'(Ver), 16'h0);
    @(negedge clk);
    Cargar = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1;
    check_all();
    idle(FR + 10, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
